// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM-like port between inst fetch and data access,
// routing in-order responses through an origin FIFO. Optional macro: SRAM_ARB_RR_EN.
`default_nettype none

module sram_port_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,

    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic ORIG_INST = 1'b0;
    localparam logic ORIG_DATA = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  own;
    logic                  own_nxt;

    logic [FIFO_DEPTH-1:0] orig_q;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  pick_data;
    logic                  sel_valid;
    logic                  sel_data;
    logic                  push;
    logic                  pop;
    logic                  head;
    logic [31:0]           rdata_mux;

`ifdef SRAM_ARB_RR_EN
    // Origin of the most recent accepted address phase; data goes first after reset.
    logic last;

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= ORIG_INST;
        end else if (push) begin
            last <= sel_data;
        end
    end

    assign pick_data = data_sram_req & (~inst_sram_req | (last == ORIG_INST));
`else
    assign pick_data = data_sram_req;
`endif

    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        sel_valid = 1'b0;
        sel_data  = ORIG_INST;

        case (state)
            IDLE: begin
                if ((count < DEPTH_C) && (inst_sram_req || data_sram_req)) begin
                    sel_valid = 1'b1;
                    sel_data  = pick_data;
                    if (!mem_addr_ok) begin
                        state_nxt = LOCKED;
                        own_nxt   = pick_data;
                    end
                end
            end
            LOCKED: begin
                // Owner keeps the port until accepted so downstream fields stay stable.
                sel_valid = 1'b1;
                sel_data  = own;
                if (mem_addr_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_wstrb = 4'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (sel_valid) begin
            if (sel_data == ORIG_DATA) begin
                mem_req   = data_sram_req;
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_wstrb = data_sram_wstrb;
                mem_addr  = data_sram_addr;
                mem_wdata = data_sram_wdata;
            end else begin
                mem_req   = inst_sram_req;
                mem_wr    = inst_sram_wr;
                mem_size  = inst_sram_size;
                mem_wstrb = inst_sram_wstrb;
                mem_addr  = inst_sram_addr;
                mem_wdata = inst_sram_wdata;
            end
        end

        push              = mem_req & mem_addr_ok;
        inst_sram_addr_ok = push & (sel_data == ORIG_INST);
        data_sram_addr_ok = push & (sel_data == ORIG_DATA);

        // A response with nothing outstanding is dropped.
        pop               = mem_data_ok & (count != '0);
        head              = orig_q[rd_ptr];
        inst_sram_data_ok = pop & (head == ORIG_INST);
        data_sram_data_ok = pop & (head == ORIG_DATA);
        rdata_mux         = pop ? mem_rdata : 32'd0;
        inst_sram_rdata   = rdata_mux;
        data_sram_rdata   = rdata_mux;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            own   <= ORIG_INST;
        end else begin
            state <= state_nxt;
            own   <= own_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            orig_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                orig_q[wr_ptr] <= sel_data;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: table-driven cycle vectors plus directed full/order/reset sequences.
`default_nettype none

module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_req, data_sram_req;
    logic        inst_sram_wr, data_sram_wr;
    logic [1:0]  inst_sram_size, data_sram_size;
    logic [3:0]  inst_sram_wstrb, data_sram_wstrb;
    logic [31:0] inst_sram_addr, data_sram_addr;
    logic [31:0] inst_sram_wdata, data_sram_wdata;
    logic        inst_sram_addr_ok, data_sram_addr_ok;
    logic        inst_sram_data_ok, data_sram_data_ok;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ireq, dreq, mao, mdo;
        logic [31:0] iaddr, daddr, mrdata;
        logic        e_mreq, e_iaok, e_daok, e_idok, e_ddok;
        logic [31:0] e_maddr, e_rdata;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ireq, dreq, mao, mdo,
                                input logic [31:0] iaddr, daddr, mrdata,
                                input logic e_mreq, e_iaok, e_daok, e_idok, e_ddok,
                                input logic [31:0] e_maddr, e_rdata);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.mao = mao; v.mdo = mdo;
        v.iaddr = iaddr; v.daddr = daddr; v.mrdata = mrdata;
        v.e_mreq = e_mreq; v.e_iaok = e_iaok; v.e_daok = e_daok;
        v.e_idok = e_idok; v.e_ddok = e_ddok;
        v.e_maddr = e_maddr; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Apply one cycle of stimulus just after a rising edge and settle to mid-cycle.
    task automatic cyc(input logic ireq, dreq, input logic [31:0] ia, da,
                       input logic mao, mdo, input logic [31:0] rd);
        inst_sram_req = ireq; inst_sram_addr = ia;
        data_sram_req = dreq; data_sram_addr = da;
        mem_addr_ok = mao; mem_data_ok = mdo; mem_rdata = rd;
        #4;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        inst_sram_wr = 1'b0; inst_sram_size = 2'd2; inst_sram_wstrb = 4'h0; inst_sram_wdata = 32'd0;
        data_sram_wr = 1'b1; data_sram_size = 2'd2; data_sram_wstrb = 4'hf; data_sram_wdata = 32'hdeadbeef;
        inst_sram_req = 0; data_sram_req = 0; inst_sram_addr = 0; data_sram_addr = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

        vecs[0]  = mk(1,0,1,0, 32'h1c000000,0,0,           1,1,0,0,0, 32'h1c000000,0);
        vecs[1]  = mk(0,0,0,0, 0,0,0,                      0,0,0,0,0, 0,0);
        vecs[2]  = mk(0,0,0,1, 0,0,32'h02800413,           0,0,0,1,0, 0,32'h02800413);
        vecs[3]  = mk(1,1,1,0, 32'h100,32'h200,0,          1,0,1,0,0, 32'h200,0);
        vecs[4]  = mk(1,0,1,1, 32'h100,0,32'h11,           1,1,0,0,1, 32'h100,32'h11);
        vecs[5]  = mk(1,1,1,1, 32'h104,32'h204,32'h22,     1,0,1,1,0, 32'h204,32'h22);
`ifdef SRAM_ARB_RR_EN
        vecs[6]  = mk(1,1,1,1, 32'h104,32'h208,32'h33,     1,1,0,0,1, 32'h104,32'h33);
        vecs[7]  = mk(0,1,1,1, 0,32'h208,32'h44,           1,0,1,1,0, 32'h208,32'h44);
        vecs[8]  = mk(0,0,0,1, 0,0,32'h55,                 0,0,0,0,1, 0,32'h55);
`else
        vecs[6]  = mk(1,1,1,1, 32'h104,32'h208,32'h33,     1,0,1,0,1, 32'h208,32'h33);
        vecs[7]  = mk(1,0,1,1, 32'h104,0,32'h44,           1,1,0,0,1, 32'h104,32'h44);
        vecs[8]  = mk(0,0,0,1, 0,0,32'h55,                 0,0,0,1,0, 0,32'h55);
`endif
        vecs[9]  = mk(0,1,0,0, 0,32'h8,0,                  1,0,0,0,0, 32'h8,0);
        vecs[10] = mk(1,1,0,0, 32'h300,32'h8,0,            1,0,0,0,0, 32'h8,0);
        vecs[11] = mk(1,1,0,0, 32'h300,32'h8,0,            1,0,0,0,0, 32'h8,0);
        vecs[12] = mk(1,1,1,0, 32'h300,32'h8,0,            1,0,1,0,0, 32'h8,0);
        vecs[13] = mk(1,0,1,0, 32'h300,0,0,                1,1,0,0,0, 32'h300,0);
        vecs[14] = mk(0,0,0,1, 0,0,32'h66,                 0,0,0,0,1, 0,32'h66);
        vecs[15] = mk(0,0,0,1, 0,0,32'h77,                 0,0,0,1,0, 0,32'h77);
        vecs[16] = mk(1,0,0,0, 32'h400,0,0,                1,0,0,0,0, 32'h400,0);
        vecs[17] = mk(1,1,1,0, 32'h400,32'h500,0,          1,1,0,0,0, 32'h400,0);
        vecs[18] = mk(0,1,1,0, 0,32'h500,0,                1,0,1,0,0, 32'h500,0);
        vecs[19] = mk(0,0,0,1, 0,0,32'h88,                 0,0,0,1,0, 0,32'h88);
        vecs[20] = mk(0,0,0,1, 0,0,32'h99,                 0,0,0,0,1, 0,32'h99);
        vecs[21] = mk(0,0,0,1, 0,0,32'haa,                 0,0,0,0,0, 0,0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #4;
        chk("reset mem_req", {31'd0, mem_req}, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset addr_ok", {30'd0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
        chk("reset data_ok", {30'd0, inst_sram_data_ok, data_sram_data_ok}, 0);
        chk("reset rdata", inst_sram_rdata | data_sram_rdata, 0);
        chk("reset count", 32'(dut.count), 0);
        tick;

        for (int i = 0; i < NV; i++) begin
            cyc(vecs[i].ireq, vecs[i].dreq, vecs[i].iaddr, vecs[i].daddr,
                vecs[i].mao, vecs[i].mdo, vecs[i].mrdata);
            chk($sformatf("v%0d mem_req", i), {31'd0, mem_req}, {31'd0, vecs[i].e_mreq});
            chk($sformatf("v%0d inst_aok", i), {31'd0, inst_sram_addr_ok}, {31'd0, vecs[i].e_iaok});
            chk($sformatf("v%0d data_aok", i), {31'd0, data_sram_addr_ok}, {31'd0, vecs[i].e_daok});
            chk($sformatf("v%0d inst_dok", i), {31'd0, inst_sram_data_ok}, {31'd0, vecs[i].e_idok});
            chk($sformatf("v%0d data_dok", i), {31'd0, data_sram_data_ok}, {31'd0, vecs[i].e_ddok});
            chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
            if (vecs[i].e_idok) chk($sformatf("v%0d inst_rdata", i), inst_sram_rdata, vecs[i].e_rdata);
            if (vecs[i].e_ddok) chk($sformatf("v%0d data_rdata", i), data_sram_rdata, vecs[i].e_rdata);
            tick;
        end
        chk("table end count", 32'(dut.count), 0);

        // FIFO full: four outstanding block the fifth until a response frees a slot.
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 32'h1000 + 32'(i * 4), 0, 1, 0, 0);
            chk($sformatf("full fill%0d aok", i), {31'd0, inst_sram_addr_ok}, 1);
            tick;
        end
        chk("full count4", 32'(dut.count), 4);
        cyc(1, 0, 32'h1010, 0, 1, 0, 0);
        chk("full blocked mem_req", {31'd0, mem_req}, 0);
        chk("full blocked aok", {31'd0, inst_sram_addr_ok}, 0);
        tick;
        cyc(1, 0, 32'h1010, 0, 1, 1, 32'hf0);
        chk("full pop mem_req", {31'd0, mem_req}, 0);
        chk("full pop dok", {31'd0, inst_sram_data_ok}, 1);
        chk("full pop rdata", inst_sram_rdata, 32'hf0);
        tick;
        cyc(1, 0, 32'h1010, 0, 1, 0, 0);
        chk("full 5th aok", {31'd0, inst_sram_addr_ok}, 1);
        chk("full 5th addr", mem_addr, 32'h1010);
        tick;
        chk("full count back4", 32'(dut.count), 4);
        cyc(0, 0, 0, 0, 0, 1, 32'hf1);
        chk("full drain1 dok", {31'd0, inst_sram_data_ok}, 1);
        tick;
        cyc(1, 0, 32'h1014, 0, 1, 1, 32'hf2);
        chk("pushpop aok", {31'd0, inst_sram_addr_ok}, 1);
        chk("pushpop dok", {31'd0, inst_sram_data_ok}, 1);
        tick;
        chk("pushpop count3", 32'(dut.count), 3);
        cyc(1, 0, 32'h1018, 0, 1, 0, 0);
        chk("refill aok", {31'd0, inst_sram_addr_ok}, 1);
        tick;
        cyc(1, 0, 32'h101c, 0, 1, 0, 0);
        chk("refull mem_req", {31'd0, mem_req}, 0);
        tick;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 32'hf3 + 32'(i));
            chk($sformatf("full drain%0d dok", i), {31'd0, inst_sram_data_ok}, 1);
            tick;
        end
        chk("full drained count", 32'(dut.count), 0);

        // Ordering: interleaved accepts return in issue order.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                cyc(1, 0, 32'h2000 + 32'(i), 0, 1, 0, 0);
                chk($sformatf("ord acc%0d inst_aok", i), {31'd0, inst_sram_addr_ok}, 1);
                chk($sformatf("ord acc%0d wr", i), {31'd0, mem_wr}, 0);
            end else begin
                cyc(0, 1, 0, 32'h3000 + 32'(i), 1, 0, 0);
                chk($sformatf("ord acc%0d data_aok", i), {31'd0, data_sram_addr_ok}, 1);
                chk($sformatf("ord acc%0d wdata", i), mem_wdata, 32'hdeadbeef);
            end
            tick;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 32'ha0 + 32'(i));
            chk($sformatf("ord rsp%0d inst_dok", i), {31'd0, inst_sram_data_ok}, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("ord rsp%0d data_dok", i), {31'd0, data_sram_data_ok}, (i % 2 == 1) ? 1 : 0);
            chk($sformatf("ord rsp%0d rdata", i),
                (i % 2 == 0) ? inst_sram_rdata : data_sram_rdata, 32'ha0 + 32'(i));
            tick;
        end

        // Reset mid-flight discards outstanding IDs.
        cyc(1, 0, 32'h4000, 0, 1, 0, 0);
        tick;
        cyc(0, 1, 0, 32'h5000, 1, 0, 0);
        tick;
        chk("rst pre count", 32'(dut.count), 2);
        cyc(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rst count0", 32'(dut.count), 0);
        cyc(0, 0, 0, 0, 0, 1, 32'hbb);
        chk("rst stray inst_dok", {31'd0, inst_sram_data_ok}, 0);
        chk("rst stray data_dok", {31'd0, data_sram_data_ok}, 0);
        tick;
        chk("rst stray count", 32'(dut.count), 0);
        cyc(0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
